// File: rtl/swpd_transfer_arbiter.sv
// Round-robin arbiter sharing one SWPD transfer engine between NUM_REQ requesters.
// Issues the engine start pulse, supervises completion/timeout and routes the reply back.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no transfer; grant to next requester when allowed
// ST_ISSUE | transfer_request pulse to engine, timeout counter loaded
// ST_WAIT  | waiting for transfer_done or timeout terminal count
// ST_RESP  | rsp_valid pulse to the granted requester
module swpd_transfer_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int GRANT_W        = 3
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_send_data,
    input  logic [2*NUM_REQ-1:0]   req_reply_len,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [13:0]            rsp_data,
    output logic                   rsp_error,
    output logic                   rsp_timeout,
    output logic                   busy,
    output logic [GRANT_W-1:0]     grant_id,
    output logic                   transfer_request,
    output logic [7:0]             send_data,
    output logic [1:0]             reply_len,
    input  logic                   transfer_running,
    input  logic                   transfer_done,
    input  logic                   transfer_error,
    input  logic [13:0]            receive_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [15:0]        TMR_LOAD  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [GRANT_W-1:0] LAST_INIT = GRANT_W'(NUM_REQ - 1);

    state_t               state;
    logic [15:0]          tmr;
    logic [GRANT_W-1:0]   last_grant;

    logic                 win_found;
    logic [GRANT_W-1:0]   win_idx;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [7:0]           win_send;
    logic [1:0]           win_len;
    logic                 grant_ok;

    // Round-robin: lowest set index above last_grant, else wrap to lowest set index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (GRANT_W'(i) > last_grant)) begin
                win_found = 1'b1;
                win_idx   = GRANT_W'(i);
            end
        end
        if (!win_found) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = GRANT_W'(i);
                end
            end
        end

        win_onehot = '0;
        win_send   = '0;
        win_len    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GRANT_W'(i) == win_idx) begin
                win_onehot[i] = 1'b1;
                win_send      = req_send_data[8*i +: 8];
                win_len       = req_reply_len[2*i +: 2];
            end
        end
    end

    assign grant_ok = enable && win_found && !transfer_running;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state            <= ST_IDLE;
            tmr              <= '0;
            last_grant       <= LAST_INIT;
            grant_id         <= '0;
            req_ready        <= '0;
            rsp_valid        <= '0;
            rsp_data         <= '0;
            rsp_error        <= 1'b0;
            rsp_timeout      <= 1'b0;
            transfer_request <= 1'b0;
            send_data        <= '0;
            reply_len        <= '0;
        end else begin
            req_ready        <= '0;
            rsp_valid        <= '0;
            transfer_request <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_ok) begin
                        req_ready        <= win_onehot;
                        send_data        <= win_send;
                        reply_len        <= win_len;
                        grant_id         <= win_idx;
                        last_grant       <= win_idx;
                        transfer_request <= 1'b1;
                        state            <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    tmr   <= TMR_LOAD;
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A completion in the terminal-count cycle still beats the timeout.
                    if (transfer_done) begin
                        rsp_data    <= receive_data;
                        rsp_error   <= transfer_error;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= NUM_REQ'(1) << grant_id;
                        state       <= ST_RESP;
                    end else if (tmr == 16'd0) begin
                        rsp_data    <= '0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= NUM_REQ'(1) << grant_id;
                        state       <= ST_RESP;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_swpd_transfer_arbiter.sv
// Randomized self-checking bench for swpd_transfer_arbiter against a transaction-level model.
module tb_swpd_transfer_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TMO     = 12;
    localparam int GW      = 3;

    logic                   ACLK;
    logic                   ARESET;
    logic                   enable;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [8*NUM_REQ-1:0]   req_send_data;
    logic [2*NUM_REQ-1:0]   req_reply_len;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [13:0]            rsp_data;
    logic                   rsp_error;
    logic                   rsp_timeout;
    logic                   busy;
    logic [GW-1:0]          grant_id;
    logic                   transfer_request;
    logic [7:0]             send_data;
    logic [1:0]             reply_len;
    logic                   transfer_running;
    logic                   transfer_done;
    logic                   transfer_error;
    logic [13:0]            receive_data;

    swpd_transfer_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TMO),
        .GRANT_W        (GW)
    ) dut (
        .ACLK             (ACLK),
        .ARESET           (ARESET),
        .enable           (enable),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_send_data    (req_send_data),
        .req_reply_len    (req_reply_len),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_error        (rsp_error),
        .rsp_timeout      (rsp_timeout),
        .busy             (busy),
        .grant_id         (grant_id),
        .transfer_request (transfer_request),
        .send_data        (send_data),
        .reply_len        (reply_len),
        .transfer_running (transfer_running),
        .transfer_done    (transfer_done),
        .transfer_error   (transfer_error),
        .receive_data     (receive_data)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int m_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Reference arbitration: first pending requester after the last winner, cyclically.
    function automatic int model_winner(input logic [NUM_REQ-1:0] mask);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (m_last + k) % NUM_REQ;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check_eq({tag, "_rsp_data"}, 32'(rsp_data), 0);
        check_eq({tag, "_rsp_error"}, 32'(rsp_error), 0);
        check_eq({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_grant_id"}, 32'(grant_id), 0);
        check_eq({tag, "_xfer_req"}, 32'(transfer_request), 0);
        check_eq({tag, "_send_data"}, 32'(send_data), 0);
        check_eq({tag, "_reply_len"}, 32'(reply_len), 0);
    endtask

    // One complete transaction. d: cycle after transfer_request on which the engine
    // pulses done (0 = never; > TMO = late pulse that lands after the abort).
    task automatic run_xfer(input logic [NUM_REQ-1:0] mask, input logic [8*NUM_REQ-1:0] sends,
                            input logic [2*NUM_REQ-1:0] lens, input int d,
                            input logic [13:0] rdata, input logic rerr);
        int w, exp_n, got_n, n_rsp, extra, last_n;
        logic timed_out;
        logic [NUM_REQ-1:0] rv_cap;
        logic [13:0] d_cap, e_data;
        logic e_cap, t_cap, e_err;
        rv_cap = '0; d_cap = '0; e_cap = 1'b0; t_cap = 1'b0;

        enable = 1'b1; transfer_running = 1'b0; transfer_done = 1'b0;
        req_valid = mask; req_send_data = sends; req_reply_len = lens;
        w = model_winner(mask);
        step();
        check_eq("req_ready", 32'(req_ready), 32'(1) << w);
        check_eq("xfer_req", 32'(transfer_request), 1);
        check_eq("send_data", 32'(send_data), 32'(sends[8*w +: 8]));
        check_eq("reply_len", 32'(reply_len), 32'(lens[2*w +: 2]));
        check_eq("grant_id", 32'(grant_id), 32'(w));
        check_eq("busy", 32'(busy), 1);
        req_valid = '0;
        m_last = w;
        // A done pulse during the issue cycle must be ignored.
        transfer_done  = 1'($urandom);
        receive_data   = 14'($urandom);
        transfer_error = 1'($urandom);

        timed_out = !(d >= 1 && d <= TMO);
        exp_n  = timed_out ? TMO + 1 : d + 1;
        last_n = ((d > exp_n) ? d : exp_n) + 2;
        got_n = 0; n_rsp = 0; extra = 0;
        for (int n = 1; n <= last_n; n++) begin
            step();
            if (rsp_valid != '0) begin
                n_rsp++;
                if (got_n == 0) begin
                    got_n = n; rv_cap = rsp_valid; d_cap = rsp_data;
                    e_cap = rsp_error; t_cap = rsp_timeout;
                end
            end
            if (transfer_request || req_ready != '0) extra++;
            transfer_done    = (n == d);
            receive_data     = (n == d) ? rdata : 14'($urandom);
            transfer_error   = (n == d) ? rerr : 1'($urandom);
            transfer_running = 1'($urandom);
            enable           = 1'($urandom);
        end
        transfer_done = 1'b0; transfer_running = 1'b0; enable = 1'b1;

        e_data = timed_out ? 14'd0 : rdata;
        e_err  = timed_out ? 1'b1 : rerr;
        check_eq("rsp_latency", 32'(got_n), 32'(exp_n));
        check_eq("rsp_count", 32'(n_rsp), 1);
        check_eq("rsp_valid", 32'(rv_cap), 32'(1) << w);
        check_eq("rsp_data", 32'(d_cap), 32'(e_data));
        check_eq("rsp_error", 32'(e_cap), 32'(e_err));
        check_eq("rsp_timeout", 32'(t_cap), 32'(timed_out));
        check_eq("no_regrant", 32'(extra), 0);
        check_eq("rsp_hold", 32'(rsp_data), 32'(e_data));
        check_eq("busy_end", 32'(busy), 0);
    endtask

    initial begin
        int n_bad;
        ARESET = 1'b1; enable = 1'b0; req_valid = '0; req_send_data = '0; req_reply_len = '0;
        transfer_running = 1'b0; transfer_done = 1'b0; transfer_error = 1'b0; receive_data = '0;
        repeat (3) step();
        check_idle_zero("in_reset");
        ARESET = 1'b0;
        step();
        check_idle_zero("post_reset");
        m_last = NUM_REQ - 1;

        // Single request, then an engine error reply.
        run_xfer(2'b01, 16'h00A5, 4'b0010, 10, 14'h1ABC, 1'b0);
        run_xfer(2'b10, 16'h3C00, 4'b0100, 3, 14'h0123, 1'b1);

        // Contention: both requesters held.
        repeat (4) run_xfer(2'b11, 16'($urandom), 4'($urandom), $urandom_range(1, 5),
                            14'($urandom), 1'($urandom));

        // Gating by enable, then by transfer_running.
        enable = 1'b0; req_valid = 2'b11; n_bad = 0;
        repeat (20) begin step(); if (req_ready != '0 || busy) n_bad++; end
        check_eq("gate_enable", 32'(n_bad), 0);
        enable = 1'b1; transfer_running = 1'b1; n_bad = 0;
        repeat (5) begin step(); if (req_ready != '0 || busy) n_bad++; end
        check_eq("gate_running", 32'(n_bad), 0);
        run_xfer(2'b11, 16'h5A69, 4'b1001, 4, 14'h2222, 1'b0);

        // Timeout, then a stray done while idle.
        run_xfer(2'b01, 16'h0011, 4'b0001, 0, 14'h0, 1'b0);
        transfer_done = 1'b1; receive_data = 14'h3FFF; transfer_error = 1'b1; n_bad = 0;
        step();
        transfer_done = 1'b0;
        repeat (4) begin step(); if (rsp_valid != '0 || busy) n_bad++; end
        check_eq("idle_done_ignored", 32'(n_bad), 0);
        check_eq("idle_done_hold", 32'(rsp_data), 0);

        // Reset while waiting on the engine.
        enable = 1'b1; req_valid = 2'b01; req_send_data = 16'h0077; req_reply_len = 4'b0011;
        step();
        check_eq("rst_pre_grant", 32'(req_ready), 32'(1) << model_winner(2'b01));
        req_valid = '0;
        repeat (3) step();
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        check_idle_zero("rst_wait");
        m_last = NUM_REQ - 1;
        n_bad = 0;
        for (int n = 0; n < 12; n++) begin
            transfer_done = (n == 2);
            step();
            if (rsp_valid != '0 || busy) n_bad++;
        end
        transfer_done = 1'b0;
        check_eq("rst_no_rsp", 32'(n_bad), 0);
        run_xfer(2'b11, 16'hBEEF, 4'b0110, 2, 14'h0ACE, 1'b0);

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            int dsel, d;
            dsel = $urandom_range(0, 9);
            if (dsel < 7)       d = $urandom_range(1, TMO);
            else if (dsel == 7) d = 0;
            else                d = TMO + $urandom_range(2, 3);
            run_xfer(NUM_REQ'($urandom_range(1, 3)), 16'($urandom), 4'($urandom), d,
                     14'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
